// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: keyboard pins in, decoded key results out.
interface ps2_key_decoder_if;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [7:0] PS2_ASCII;
   logic       oKEY_VALID;
   logic [7:0] oSCANCODE;
   logic       oFRAME_ERR;

   // keyboard side (drives the pins, observes results)
   modport master (
      output PS2_CLK, PS2_DAT,
      input  PS2_ASCII, oKEY_VALID, oSCANCODE, oFRAME_ERR
   );

   // decoder side
   modport slave (
      input  PS2_CLK, PS2_DAT,
      output PS2_ASCII, oKEY_VALID, oSCANCODE, oFRAME_ERR
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: pin conditioning, frame FSM, prefix/make/break
// byte layer and a level-held ASCII output for the game-control logic.
//
// state  | meaning
// IDLE   | waiting for a start bit (DAT low on a filtered clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, accepting or rejecting the byte
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input logic iCLK,
   input logic iRST,
   ps2_key_decoder_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state, state_n;
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] tmr;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic          fall, timeout;
   logic          shift_en, par_en, byte_ok, err;
   logic          byte_stb, ext, brk;
   logic [8:0]    held;
   logic [7:0]    ascii_q, scancode_q;
   logic          key_valid_q, frame_err_q;
   logic [8:0]    key;
   logic [7:0]    key_ascii;

   // set-2 code to ASCII; 0x00 means the code is not mapped
   function automatic logic [7:0] map_key(input logic [8:0] k);
      logic [7:0] a;
      a = 8'h00;
      case (k)
         9'h01C: a = 8'h61;  9'h032: a = 8'h62;  9'h021: a = 8'h63;
         9'h023: a = 8'h64;  9'h024: a = 8'h65;  9'h02B: a = 8'h66;
         9'h034: a = 8'h67;  9'h033: a = 8'h68;  9'h043: a = 8'h69;
         9'h03B: a = 8'h6A;  9'h042: a = 8'h6B;  9'h04B: a = 8'h6C;
         9'h03A: a = 8'h6D;  9'h031: a = 8'h6E;  9'h044: a = 8'h6F;
         9'h04D: a = 8'h70;  9'h015: a = 8'h71;  9'h02D: a = 8'h72;
         9'h01B: a = 8'h73;  9'h02C: a = 8'h74;  9'h03C: a = 8'h75;
         9'h02A: a = 8'h76;  9'h01D: a = 8'h77;  9'h022: a = 8'h78;
         9'h035: a = 8'h79;  9'h01A: a = 8'h7A;
         9'h029: a = 8'h20;  9'h05A: a = 8'h0D;
         9'h16B: a = 8'h61;  9'h174: a = 8'h64;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   // the fall is taken in the same cycle the filter commits the new low level
   assign fall    = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));
   assign timeout = (state != IDLE) && !fall && (tmr == '0);

   // two-flop synchronizers and glitch filter on the keyboard clock
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1 <= bus.PS2_CLK;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.PS2_DAT;
         dat_s2 <= dat_s1;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // frame state register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= state_n;
   end

   // frame next-state and strobes
   always_comb begin
      state_n  = state;
      shift_en = 1'b0;
      par_en   = 1'b0;
      byte_ok  = 1'b0;
      err      = 1'b0;
      if (timeout) begin
         state_n = IDLE;
         err     = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE:   if (!dat_s2) state_n = DATA;
            DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_en  = 1'b1;
               state_n = STOP;
            end
            STOP: begin
               if (dat_s2 && (^{shreg, par})) byte_ok = 1'b1;
               else                           err     = 1'b1;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // frame datapath and inter-edge timeout down-counter
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         tmr     <= TW'(TIMEOUT_CYCLES - 1);
      end else begin
         if (fall)                tmr <= TW'(TIMEOUT_CYCLES - 1);
         else if (tmr != '0)      tmr <= tmr - 1'b1;
         if (state == IDLE)       bit_cnt <= '0;
         if (shift_en) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (par_en) par <= dat_s2;
      end
   end

   assign key       = {ext, scancode_q};
   assign key_ascii = map_key(key);

   // byte layer: prefixes, make/break tracking and the held ASCII level
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scancode_q  <= '0;
         byte_stb    <= 1'b0;
         frame_err_q <= 1'b0;
         key_valid_q <= 1'b0;
         ascii_q     <= '0;
         held        <= '0;
         ext         <= 1'b0;
         brk         <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= err;
         byte_stb    <= byte_ok;
         if (byte_ok) scancode_q <= shreg;
         if (err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_stb) begin
            if (scancode_q == 8'hE0) begin
               ext <= 1'b1;
            end else if (scancode_q == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!brk) begin
                  if (key_ascii != 8'h00) begin
                     ascii_q     <= key_ascii;
                     held        <= key;
                     key_valid_q <= 1'b1;
                  end
               end else if (key == held) begin
                  ascii_q <= 8'h00;
                  held    <= '0;
               end
            end
         end
      end
   end

   assign bus.PS2_ASCII  = ascii_q;
   assign bus.oKEY_VALID = key_valid_q;
   assign bus.oSCANCODE  = scancode_q;
   assign bus.oFRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, checks on the
// held ASCII, raw scancode and pulse counts after each step.
module tb_ps2_key_decoder;
   logic iCLK = 1'b0;
   logic iRST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   kv_cnt = 0;
   int   fe_cnt = 0;

   localparam int FAST = 20;    // half-period in iCLK cycles for most frames
   localparam int SLOW = 2000;  // 12.5 kHz keyboard clock at 50 MHz

   ps2_key_decoder_if bus ();

   ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(10000)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus.slave)
   );

   always #10 iCLK = ~iCLK;

   always @(posedge iCLK) begin
      if (bus.oKEY_VALID === 1'b1) kv_cnt++;
      if (bus.oFRAME_ERR === 1'b1) fe_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int half);
      bus.PS2_DAT = b;
      wait_cyc(half);
      bus.PS2_CLK = 1'b0;
      wait_cyc(half);
      bus.PS2_CLK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int half);
      send_bit(1'b0, half);
      for (int i = 0; i < 8; i++) send_bit(b[i], half);
      send_bit((~^b) ^ bad_par, half);
      send_bit(1'b1, half);
      wait_cyc(30);
   endtask

   task automatic clr_cnt();
      kv_cnt = 0;
      fe_cnt = 0;
   endtask

   initial begin
      bus.PS2_CLK = 1'b1;
      bus.PS2_DAT = 1'b1;
      iRST = 1'b1;
      wait_cyc(3);
      iRST = 1'b0;
      wait_cyc(3);
      chk("rst_ascii", bus.PS2_ASCII, 8'h00);
      chk("rst_scan", bus.oSCANCODE, 8'h00);
      chk("rst_valid", bus.oKEY_VALID, 1'b0);
      chk("rst_err", bus.oFRAME_ERR, 1'b0);

      // single make at real keyboard speed
      clr_cnt();
      send_frame(8'h23, 1'b0, SLOW);
      chk("slow_scan", bus.oSCANCODE, 8'h23);
      chk("slow_ascii", bus.PS2_ASCII, 8'h64);
      chk("slow_kv", kv_cnt, 1);
      chk("slow_fe", fe_cnt, 0);

      // typematic repeat, then break
      clr_cnt();
      send_frame(8'h23, 1'b0, FAST);
      chk("rep_kv", kv_cnt, 1);
      send_frame(8'hF0, 1'b0, FAST);
      chk("f0_scan", bus.oSCANCODE, 8'hF0);
      chk("f0_ascii", bus.PS2_ASCII, 8'h64);
      chk("f0_kv", kv_cnt, 1);
      send_frame(8'h23, 1'b0, FAST);
      chk("brk_ascii", bus.PS2_ASCII, 8'h00);
      chk("brk_kv", kv_cnt, 1);

      // bad parity keeps the held value
      send_frame(8'h29, 1'b0, FAST);
      chk("sp_ascii", bus.PS2_ASCII, 8'h20);
      clr_cnt();
      send_frame(8'h1C, 1'b1, FAST);
      chk("par_fe", fe_cnt, 1);
      chk("par_ascii", bus.PS2_ASCII, 8'h20);
      chk("par_kv", kv_cnt, 0);
      send_frame(8'h1C, 1'b0, FAST);
      chk("par_next", bus.PS2_ASCII, 8'h61);

      // truncated frame times out
      clr_cnt();
      send_bit(1'b0, FAST);
      for (int i = 0; i < 5; i++) send_bit(1'b1, FAST);
      bus.PS2_DAT = 1'b1;
      wait_cyc(10010);
      chk("to_fe", fe_cnt, 1);
      chk("to_ascii", bus.PS2_ASCII, 8'h61);
      send_frame(8'h29, 1'b0, FAST);
      chk("to_next", bus.PS2_ASCII, 8'h20);
      chk("to_next_fe", fe_cnt, 1);

      // extended right arrow make and break
      send_frame(8'hE0, 1'b0, FAST);
      send_frame(8'h74, 1'b0, FAST);
      chk("ext_make", bus.PS2_ASCII, 8'h64);
      send_frame(8'hE0, 1'b0, FAST);
      send_frame(8'hF0, 1'b0, FAST);
      send_frame(8'h74, 1'b0, FAST);
      chk("ext_brk", bus.PS2_ASCII, 8'h00);

      // last-pressed wins; stale break ignored
      clr_cnt();
      send_frame(8'h1C, 1'b0, FAST);
      chk("lp_a", bus.PS2_ASCII, 8'h61);
      send_frame(8'h23, 1'b0, FAST);
      send_frame(8'hF0, 1'b0, FAST);
      send_frame(8'h1C, 1'b0, FAST);
      chk("lp_ascii", bus.PS2_ASCII, 8'h64);
      chk("lp_kv", kv_cnt, 2);
      chk("lp_scan", bus.oSCANCODE, 8'h1C);

      // short clock glitch with data low must not start a frame
      clr_cnt();
      bus.PS2_DAT = 1'b0;
      bus.PS2_CLK = 1'b0;
      wait_cyc(3);
      bus.PS2_CLK = 1'b1;
      wait_cyc(20);
      bus.PS2_DAT = 1'b1;
      wait_cyc(5);
      chk("gl_scan", bus.oSCANCODE, 8'h1C);
      send_frame(8'h29, 1'b0, FAST);
      chk("gl_next_scan", bus.oSCANCODE, 8'h29);
      chk("gl_next_ascii", bus.PS2_ASCII, 8'h20);
      chk("gl_fe", fe_cnt, 0);

      // reset in the middle of a frame
      send_bit(1'b0, FAST);
      send_bit(1'b1, FAST);
      send_bit(1'b1, FAST);
      send_bit(1'b0, FAST);
      iRST = 1'b1;
      wait_cyc(2);
      chk("mr_ascii", bus.PS2_ASCII, 8'h00);
      chk("mr_scan", bus.oSCANCODE, 8'h00);
      chk("mr_valid", bus.oKEY_VALID, 1'b0);
      chk("mr_err", bus.oFRAME_ERR, 1'b0);
      bus.PS2_DAT = 1'b1;
      wait_cyc(2);
      iRST = 1'b0;
      wait_cyc(5);
      clr_cnt();
      send_frame(8'h23, 1'b0, FAST);
      chk("mr_next_ascii", bus.PS2_ASCII, 8'h64);
      chk("mr_next_scan", bus.oSCANCODE, 8'h23);
      chk("mr_next_fe", fe_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
